// File: rtl/axi_stream_cache_pkt_if.sv
// axi_stream_cache_pkt_if: AXI-Stream bundle shared by the cache's upstream and downstream sides
// Signals: tdata, tkeep, tuser, tlast, tvalid (source to sink), tready (sink to source).
// Modports: master drives the payload and tvalid; slave drives tready.
interface axi_stream_cache_pkt_if #(
    parameter int DSIZE = 32,
    parameter int KSIZE = (DSIZE / 8 > 0) ? DSIZE / 8 : 1,
    parameter int USIZE = 1
);
    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic [USIZE-1:0] tuser;
    logic             tlast;
    logic             tvalid;
    logic             tready;
    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axi_stream_cache_pkt.sv
// axi_stream_cache_pkt: AXI-Stream buffer with cut-through or store-and-forward packet mode
// Ports: aclk; aresetn (synchronous, active-low);
//   axis_in  (slave)  upstream stream, tready registered;
//   axis_out (master) downstream stream from a first-word-fall-through output register;
//   level = beats held, pkt_cnt = complete packets not yet fully read,
//   ovf_pkt = one-cycle pulse when an oversize packet forces a flush.
// Option: define AXIS_CACHE_SIDEBAND_EN to store tkeep/tuser per beat; otherwise
//   tkeep reads all ones and tuser reads zero.
module axi_stream_cache_pkt #(
    parameter int DSIZE    = 32,
    parameter int DEPTH    = 256,
    parameter int PKT_MODE = 0,
    parameter int KSIZE    = (DSIZE / 8 > 0) ? DSIZE / 8 : 1,
    parameter int USIZE    = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi_stream_cache_pkt_if.slave  axis_in,
    axi_stream_cache_pkt_if.master axis_out,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] pkt_cnt,
    output logic                   ovf_pkt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
`ifdef AXIS_CACHE_SIDEBAND_EN
    localparam int W = DSIZE + KSIZE + USIZE + 1;
`else
    localparam int W = DSIZE + 1;
`endif
    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;
    state_t       state;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] in_word, out_word;
    logic [AW:0]  wr_ptr, rd_ptr, level_nx, pkt_nx, mem_pkts;
    logic         in_ready, out_valid, out_last, wr, rd, load, load_ok;
    assign wr       = axis_in.tvalid && in_ready;
    assign rd       = out_valid && axis_out.tready;
    assign out_last = out_word[DSIZE];
    assign level_nx = level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    assign pkt_nx   = pkt_cnt + {{AW{1'b0}}, wr && axis_in.tlast} - {{AW{1'b0}}, rd && out_last};
    // Complete packets still in memory, i.e. excluding a tlast beat already in the output register.
    assign mem_pkts = pkt_cnt - {{AW{1'b0}}, out_valid && out_last};
    // Packet mode only fetches beats of complete packets; FLUSH fetches up to the oversize tlast.
    assign load_ok  = PKT_MODE == 0 ? 1'b1 : state == FLUSH ? !(out_valid && out_last) :
                      state != IDLE || pkt_cnt != '0 ? mem_pkts != '0 : 1'b0;
    assign load     = wr_ptr != rd_ptr && (!out_valid || rd) && load_ok;
    always_ff @(posedge aclk) begin
        if (wr) mem[wr_ptr[AW-1:0]] <= in_word;
        if (load) out_word <= mem[rd_ptr[AW-1:0]];
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            ovf_pkt   <= 1'b0;
            state     <= IDLE;
        end else begin
            wr_ptr    <= wr_ptr + {{AW{1'b0}}, wr};
            rd_ptr    <= rd_ptr + {{AW{1'b0}}, load};
            level     <= level_nx;
            pkt_cnt   <= pkt_nx;
            in_ready  <= level_nx != FULL;
            out_valid <= load || (out_valid && !rd);
            ovf_pkt   <= PKT_MODE != 0 && state == IDLE && pkt_cnt == '0 && level == FULL;
            state     <= PKT_MODE == 0 ? IDLE :
                         state == IDLE ? (pkt_cnt != '0 ? SEND : level == FULL ? FLUSH : IDLE) :
                         rd && out_last && (state == FLUSH || pkt_nx == '0) ? IDLE : state;
        end
    end
    assign axis_in.tready  = in_ready;
    assign axis_out.tvalid = out_valid;
    assign axis_out.tdata  = out_word[DSIZE-1:0];
    assign axis_out.tlast  = out_last;
`ifdef AXIS_CACHE_SIDEBAND_EN
    assign in_word        = {axis_in.tuser, axis_in.tkeep, axis_in.tlast, axis_in.tdata};
    assign axis_out.tkeep = out_word[DSIZE+1 +: KSIZE];
    assign axis_out.tuser = out_word[DSIZE+1+KSIZE +: USIZE];
`else
    logic unused_sideband;
    assign unused_sideband = ^{axis_in.tkeep, axis_in.tuser};
    assign in_word        = {axis_in.tlast, axis_in.tdata};
    assign axis_out.tkeep = '1;
    assign axis_out.tuser = '0;
`endif
endmodule

// File: tb/tb_axi_stream_cache_pkt.sv
// tb_axi_stream_cache_pkt: directed and randomized checks of the stream cache in both modes
// u_ct is a 16-deep cut-through buffer, u_pk an 8-deep store-and-forward buffer.
module tb_axi_stream_cache_pkt;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        u;
        logic        l;
    } beat_t;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [4:0] c_level, c_pkt;
    logic [3:0] p_level, p_pkt;
    logic c_ovf, p_ovf;
    int n_chk = 0;
    int n_fail = 0;
    always #5 aclk = ~aclk;
    axi_stream_cache_pkt_if #(.DSIZE(32)) ci ();
    axi_stream_cache_pkt_if #(.DSIZE(32)) co ();
    axi_stream_cache_pkt_if #(.DSIZE(32)) pi ();
    axi_stream_cache_pkt_if #(.DSIZE(32)) po ();
    axi_stream_cache_pkt #(.DSIZE(32), .DEPTH(16), .PKT_MODE(0)) u_ct (
        .aclk(aclk), .aresetn(aresetn), .axis_in(ci), .axis_out(co),
        .level(c_level), .pkt_cnt(c_pkt), .ovf_pkt(c_ovf));
    axi_stream_cache_pkt #(.DSIZE(32), .DEPTH(8), .PKT_MODE(1)) u_pk (
        .aclk(aclk), .aresetn(aresetn), .axis_in(pi), .axis_out(po),
        .level(p_level), .pkt_cnt(p_pkt), .ovf_pkt(p_ovf));

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        ci.tvalid = 0; ci.tdata = 0; ci.tkeep = '1; ci.tuser = 0; ci.tlast = 0; co.tready = 0;
        pi.tvalid = 0; pi.tdata = 0; pi.tkeep = '1; pi.tuser = 0; pi.tlast = 0; po.tready = 0;
        aresetn = 0;
        tick();
        tick();
        n_chk++;
        if (c_level !== 0 || c_pkt !== 0 || co.tvalid !== 0 || ci.tready !== 0 || c_ovf !== 0) begin
            n_fail++;
            $display("FAIL reset_ct: level=%0d pkt=%0d tvalid=%b tready=%b ovf=%b, want all 0", c_level, c_pkt, co.tvalid, ci.tready, c_ovf);
        end
        n_chk++;
        if (p_level !== 0 || p_pkt !== 0 || po.tvalid !== 0 || pi.tready !== 0 || p_ovf !== 0) begin
            n_fail++;
            $display("FAIL reset_pk: level=%0d pkt=%0d tvalid=%b tready=%b ovf=%b, want all 0", p_level, p_pkt, po.tvalid, pi.tready, p_ovf);
        end
        aresetn = 1;
        tick();
        n_chk++;
        if (ci.tready !== 1 || pi.tready !== 1) begin
            n_fail++;
            $display("FAIL reset_release: tready ct=%b pk=%b, want 1 1", ci.tready, pi.tready);
        end
    endtask

    task automatic test_cut_through();
        co.tready = 1; ci.tdata = 32'h11; ci.tlast = 0; ci.tvalid = 1;
        n_chk++;
        if (c_level !== 0) begin n_fail++; $display("FAIL ct_level0: level=%0d want 0", c_level); end
        tick();
        ci.tvalid = 0;
        n_chk++;
        if (c_level !== 1 || co.tvalid !== 0) begin
            n_fail++; $display("FAIL ct_edge1: level=%0d tvalid=%b, want 1 0", c_level, co.tvalid);
        end
        tick();
        n_chk++;
        if (co.tvalid !== 1 || co.tdata !== 32'h11 || co.tkeep !== 4'hf || co.tuser !== 1'b0 || c_level !== 1) begin
            n_fail++;
            $display("FAIL ct_edge2: tvalid=%b tdata=%h tkeep=%h tuser=%b level=%0d, want 1 11 f 0 1", co.tvalid, co.tdata, co.tkeep, co.tuser, c_level);
        end
        tick();
        n_chk++;
        if (c_level !== 0 || co.tvalid !== 0) begin
            n_fail++; $display("FAIL ct_edge3: level=%0d tvalid=%b, want 0 0", c_level, co.tvalid);
        end
        co.tready = 0;
    endtask

    task automatic test_fill();
        co.tready = 0; ci.tvalid = 1; ci.tlast = 0;
        for (int i = 0; i < 16; i++) begin
            ci.tdata = i;
            n_chk++;
            if (ci.tready !== 1) begin n_fail++; $display("FAIL fill_ready: beat %0d tready=%b want 1", i, ci.tready); end
            tick();
            n_chk++;
            if (c_level !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_level: level=%0d want %0d", c_level, i + 1); end
        end
        ci.tdata = 16;
        tick();
        tick();
        n_chk++;
        if (ci.tready !== 0 || c_level !== 16) begin
            n_fail++; $display("FAIL fill_full: tready=%b level=%0d, want 0 16", ci.tready, c_level);
        end
        ci.tvalid = 0; co.tready = 1;
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (co.tvalid !== 1 || co.tdata !== 32'(k)) begin
                n_fail++; $display("FAIL fill_order: tvalid=%b tdata=%0d, want 1 %0d", co.tvalid, co.tdata, k);
            end
            tick();
            if (k == 0) begin
                n_chk++;
                if (ci.tready !== 1 || c_level !== 15) begin
                    n_fail++; $display("FAIL fill_ready_back: tready=%b level=%0d, want 1 15", ci.tready, c_level);
                end
            end
        end
        n_chk++;
        if (c_level !== 0 || co.tvalid !== 0) begin
            n_fail++; $display("FAIL fill_drain: level=%0d tvalid=%b, want 0 0", c_level, co.tvalid);
        end
        co.tready = 0;
    endtask

    task automatic test_random_ct();
        beat_t q[$];
        beat_t b;
        logic wr, rd, hold;
        logic [3:0] exp_k;
        logic exp_u;
        int c;
        hold = 0;
        for (c = 0; c < 1500 && !(c >= 600 && q.size() == 0); c++) begin
            n_chk++;
            if (c_level !== 5'(q.size())) begin n_fail++; $display("FAIL rnd_ct_level: level=%0d want %0d", c_level, q.size()); end
            n_chk++;
            if (ci.tready !== (q.size() != 16)) begin n_fail++; $display("FAIL rnd_ct_ready: tready=%b want %b", ci.tready, q.size() != 16); end
            if (q.size() >= 2 || hold) begin
                n_chk++;
                if (co.tvalid !== 1) begin n_fail++; $display("FAIL rnd_ct_valid: tvalid=%b want 1 (stored %0d)", co.tvalid, q.size()); end
            end
            if (co.tvalid === 1) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_ct_phantom: tvalid=1 tdata=%h, want no beat", co.tdata);
                end else begin
`ifdef AXIS_CACHE_SIDEBAND_EN
                    exp_k = q[0].k; exp_u = q[0].u;
`else
                    exp_k = 4'hf; exp_u = 1'b0;
`endif
                    if (co.tdata !== q[0].d || co.tlast !== q[0].l || co.tkeep !== exp_k || co.tuser !== exp_u) begin
                        n_fail++;
                        $display("FAIL rnd_ct_data: got %h/%b/%h/%b want %h/%b/%h/%b", co.tdata, co.tlast, co.tkeep, co.tuser, q[0].d, q[0].l, exp_k, exp_u);
                    end
                end
            end
            b = {$urandom, 6'($urandom)};
            ci.tvalid = c < 560 && $urandom_range(0, 2) != 0;
            ci.tdata = b.d; ci.tkeep = b.k; ci.tuser = b.u; ci.tlast = b.l;
            co.tready = c >= 560 ? 1'b1 : (c >= 200 && c < 320) ? $urandom_range(0, 7) == 0 : $urandom_range(0, 3) != 0;
            wr = ci.tvalid && ci.tready;
            rd = co.tvalid && co.tready;
            hold = co.tvalid && !co.tready;
            tick();
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(b);
        end
        n_chk++;
        if (q.size() != 0 || c_level !== 0) begin
            n_fail++; $display("FAIL rnd_ct_drain: left %0d beats level=%0d, want 0 0", q.size(), c_level);
        end
        ci.tvalid = 0; ci.tkeep = '1; ci.tuser = 0; ci.tlast = 0; co.tready = 0;
    endtask

    task automatic test_pkt_single();
        po.tready = 1; pi.tvalid = 1;
        for (int i = 0; i < 5; i++) begin
            pi.tdata = 32'h500 + i; pi.tlast = i == 4;
            tick();
            n_chk++;
            if (po.tvalid !== 0) begin n_fail++; $display("FAIL pkt5_early: tvalid=%b after beat %0d, want 0", po.tvalid, i); end
        end
        pi.tvalid = 0; pi.tlast = 0;
        n_chk++;
        if (p_pkt !== 1) begin n_fail++; $display("FAIL pkt5_cnt1: pkt_cnt=%0d want 1", p_pkt); end
        tick();
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (po.tvalid !== 1 || po.tdata !== 32'h500 + k || po.tlast !== (k == 4)) begin
                n_fail++; $display("FAIL pkt5_read: tvalid=%b tdata=%h tlast=%b, want 1 %h %b", po.tvalid, po.tdata, po.tlast, 32'h500 + k, k == 4);
            end
            tick();
        end
        n_chk++;
        if (p_pkt !== 0 || po.tvalid !== 0 || p_level !== 0) begin
            n_fail++; $display("FAIL pkt5_end: pkt=%0d tvalid=%b level=%0d, want 0 0 0", p_pkt, po.tvalid, p_level);
        end
        po.tready = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h300; exp_d[1] = 32'h301; exp_d[2] = 32'h302; exp_d[3] = 32'h3f0;
        po.tready = 1; pi.tvalid = 1;
        for (int i = 0; i < 4; i++) begin
            pi.tdata = exp_d[i]; pi.tlast = i >= 2;
            tick();
        end
        pi.tvalid = 0; pi.tlast = 0;
        n_chk++;
        if (p_pkt !== 2 || po.tvalid !== 1) begin
            n_fail++; $display("FAIL b2b_start: pkt=%0d tvalid=%b, want 2 1", p_pkt, po.tvalid);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (po.tvalid !== 1 || po.tdata !== exp_d[k] || po.tlast !== (k >= 2)) begin
                n_fail++; $display("FAIL b2b_read: tvalid=%b tdata=%h tlast=%b, want 1 %h %b", po.tvalid, po.tdata, po.tlast, exp_d[k], k >= 2);
            end
            tick();
            n_chk++;
            if (p_pkt !== 4'(k < 2 ? 2 : k == 2 ? 1 : 0)) begin
                n_fail++; $display("FAIL b2b_cnt: pkt=%0d after read %0d, want %0d", p_pkt, k, k < 2 ? 2 : k == 2 ? 1 : 0);
            end
        end
        po.tready = 0;
    endtask

    task automatic test_overflow();
        int wi, rj, pulses, cyc;
        wi = 0; rj = 0; pulses = 0; cyc = 0;
        po.tready = 1;
        while (rj < 12 && cyc < 300) begin
            if (po.tvalid === 1) begin
                n_chk++;
                if (po.tdata !== 32'h700 + rj || po.tlast !== (rj == 11)) begin
                    n_fail++; $display("FAIL ovf_data: tdata=%h tlast=%b, want %h %b", po.tdata, po.tlast, 32'h700 + rj, rj == 11);
                end
                rj++;
            end
            if (p_ovf === 1) begin
                pulses++;
                n_chk++;
                if (p_level !== 8) begin n_fail++; $display("FAIL ovf_level: level=%0d at pulse, want 8", p_level); end
            end
            pi.tvalid = wi < 12; pi.tdata = 32'h700 + wi; pi.tlast = wi == 11;
            if (pi.tvalid && pi.tready) wi++;
            tick();
            cyc++;
        end
        pi.tvalid = 0; pi.tlast = 0;
        n_chk++;
        if (rj != 12 || pulses != 1) begin
            n_fail++; $display("FAIL ovf_count: read %0d beats with %0d pulses, want 12 and 1", rj, pulses);
        end
        n_chk++;
        if (p_pkt !== 0 || p_level !== 0 || po.tvalid !== 0) begin
            n_fail++; $display("FAIL ovf_end: pkt=%0d level=%0d tvalid=%b, want 0 0 0", p_pkt, p_level, po.tvalid);
        end
        pi.tvalid = 1; pi.tdata = 32'h7a0;
        tick();
        pi.tdata = 32'h7a1; pi.tlast = 1;
        tick();
        pi.tvalid = 0; pi.tlast = 0;
        n_chk++;
        if (po.tvalid !== 0) begin n_fail++; $display("FAIL ovf_idle: tvalid=%b before packet release, want 0", po.tvalid); end
        tick();
        n_chk++;
        if (po.tvalid !== 1 || po.tdata !== 32'h7a0) begin
            n_fail++; $display("FAIL ovf_next0: tvalid=%b tdata=%h, want 1 7a0", po.tvalid, po.tdata);
        end
        tick();
        n_chk++;
        if (po.tvalid !== 1 || po.tdata !== 32'h7a1 || po.tlast !== 1) begin
            n_fail++; $display("FAIL ovf_next1: tvalid=%b tdata=%h tlast=%b, want 1 7a1 1", po.tvalid, po.tdata, po.tlast);
        end
        tick();
        po.tready = 0;
    endtask

    task automatic test_random_pkt();
        beat_t q[$];
        beat_t b;
        logic wr, rd, mid;
        int rem, npk, c;
        rem = $urandom_range(1, 6);
        mid = 0;
        for (c = 0; c < 1500 && !(c >= 600 && q.size() == 0 && !mid); c++) begin
            npk = 0;
            foreach (q[i]) if (q[i].l) npk++;
            n_chk++;
            if (p_level !== 4'(q.size()) || p_pkt !== 4'(npk) || p_ovf !== 0) begin
                n_fail++; $display("FAIL rnd_pk_count: level=%0d pkt=%0d ovf=%b, want %0d %0d 0", p_level, p_pkt, p_ovf, q.size(), npk);
            end
            if (po.tvalid === 1) begin
                n_chk++;
                if (npk == 0 || po.tdata !== q[0].d || po.tlast !== q[0].l) begin
                    n_fail++; $display("FAIL rnd_pk_data: tdata=%h tlast=%b with %0d complete packets, want %h %b", po.tdata, po.tlast, npk, q.size() ? q[0].d : 0, q.size() ? q[0].l : 0);
                end
            end
            b = {$urandom, 6'($urandom)};
            b.l = rem == 1;
            pi.tvalid = (c < 540 || mid) && $urandom_range(0, 2) != 0;
            pi.tdata = b.d; pi.tkeep = b.k; pi.tuser = b.u; pi.tlast = b.l;
            po.tready = c >= 560 ? 1'b1 : $urandom_range(0, 3) != 0;
            wr = pi.tvalid && pi.tready;
            rd = po.tvalid && po.tready;
            tick();
            if (rd) void'(q.pop_front());
            if (wr) begin
                q.push_back(b);
                rem = rem == 1 ? $urandom_range(1, 6) : rem - 1;
                mid = !b.l;
            end
        end
        n_chk++;
        if (q.size() != 0 || p_level !== 0) begin
            n_fail++; $display("FAIL rnd_pk_drain: left %0d beats level=%0d, want 0 0", q.size(), p_level);
        end
        pi.tvalid = 0; pi.tkeep = '1; pi.tuser = 0; pi.tlast = 0; po.tready = 0;
    endtask

    task automatic test_reset_mid();
        co.tready = 0; po.tready = 0; ci.tvalid = 1; pi.tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            ci.tdata = 32'hd00 + i; ci.tlast = i == 0;
            pi.tdata = 32'he00 + i; pi.tlast = 0;
            tick();
        end
        ci.tvalid = 0; pi.tvalid = 0; ci.tlast = 0;
        n_chk++;
        if (c_level !== 3 || c_pkt !== 1 || p_level !== 3) begin
            n_fail++; $display("FAIL rst_mid_pre: ct level=%0d pkt=%0d pk level=%0d, want 3 1 3", c_level, c_pkt, p_level);
        end
        aresetn = 0;
        tick();
        aresetn = 1;
        n_chk++;
        if (c_level !== 0 || c_pkt !== 0 || co.tvalid !== 0 || ci.tready !== 0 ||
            p_level !== 0 || p_pkt !== 0 || po.tvalid !== 0 || pi.tready !== 0) begin
            n_fail++;
            $display("FAIL rst_mid: ct %0d/%0d/%b/%b pk %0d/%0d/%b/%b (level/pkt/tvalid/tready), want all 0", c_level, c_pkt, co.tvalid, ci.tready, p_level, p_pkt, po.tvalid, pi.tready);
        end
        tick();
        n_chk++;
        if (ci.tready !== 1 || pi.tready !== 1) begin
            n_fail++; $display("FAIL rst_mid_ready: tready ct=%b pk=%b, want 1 1", ci.tready, pi.tready);
        end
        co.tready = 1; po.tready = 1;
        repeat (5) begin
            tick();
            n_chk++;
            if (co.tvalid !== 0 || po.tvalid !== 0) begin
                n_fail++; $display("FAIL rst_mid_stale: tvalid ct=%b pk=%b, want 0 0", co.tvalid, po.tvalid);
            end
        end
        ci.tvalid = 1; ci.tdata = 32'hbeef;
        tick();
        ci.tvalid = 0;
        tick();
        n_chk++;
        if (co.tvalid !== 1 || co.tdata !== 32'hbeef) begin
            n_fail++; $display("FAIL rst_mid_fresh: tvalid=%b tdata=%h, want 1 beef", co.tvalid, co.tdata);
        end
        tick();
        co.tready = 0; po.tready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cut_through();
        test_fill();
        test_random_ct();
        test_pkt_single();
        test_back_to_back();
        test_overflow();
        test_random_pkt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
